// File: rtl/aes_lite_pkg.sv
// Shared constants for the AES-lite core: nibble S-boxes, FSM states and mode encodings.
// S-box tables are packed so that entry i sits at bits [4*i +: 4].
package aes_lite_pkg;

  typedef enum logic [1:0] {
    IDLE,
    KEYEXP,
    ENC,
    DEC
  } state_e;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  // PRESENT S-box: 0..F -> C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2
  localparam logic [63:0] SBOX     = 64'h21748FE3DA09B65C;
  localparam logic [63:0] INV_SBOX = 64'hA970364BD21C8FE5;

  function automatic int cnt_width(input int num_rounds);
    return $clog2(num_rounds + 1);
  endfunction

endpackage

// File: rtl/aes_lite_round.sv
// Combinational round datapath: forward round + key step (dir_i=0) or inverse round + inverse key step (dir_i=1).
// rc_i is the zero-extended round number r; k_i is k_{r-1} forward, k_r inverse.
module aes_lite_round
  import aes_lite_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ROT    = 3
) (
  input  logic              dir_i,
  input  logic [DATA_W-1:0] s_i,
  input  logic [DATA_W-1:0] k_i,
  input  logic [DATA_W-1:0] rc_i,
  output logic [DATA_W-1:0] s_o,
  output logic [DATA_W-1:0] k_o
);

  function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] x, input int n);
    return (x << n) | (x >> (DATA_W - n));
  endfunction

  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x, input int n);
    return (x >> n) | (x << (DATA_W - n));
  endfunction

  function automatic logic [DATA_W-1:0] sub(input logic [DATA_W-1:0] x, input logic inv);
    logic [DATA_W-1:0] y;
    y = '0;
    for (int i = 0; i < DATA_W / 4; i++) begin
      y[4*i +: 4] = inv ? INV_SBOX[{x[4*i +: 4], 2'b00} +: 4]
                        : SBOX[{x[4*i +: 4], 2'b00} +: 4];
    end
    return y;
  endfunction

  logic [DATA_W-1:0] k_fwd, k_inv, s_fwd, s_inv;

  // Forward round mixes in the freshly stepped key k_r; inverse strips k_r first.
  assign k_fwd = rotl(k_i, 1) ^ rc_i;
  assign k_inv = rotr(k_i ^ rc_i, 1);
  assign s_fwd = rotl(sub(s_i, 1'b0), ROT) ^ k_fwd;
  assign s_inv = sub(rotr(s_i ^ k_i, ROT), 1'b1);

  assign s_o = (dir_i == MODE_DEC) ? s_inv : s_fwd;
  assign k_o = (dir_i == MODE_DEC) ? k_inv : k_fwd;

endmodule

// File: rtl/aes_lite_core.sv
// Iterative nibble SPN cipher: encrypt N cycles, decrypt 2N (key expansion then inverse rounds); start ignored while busy.
// AES_LITE_KEY_CACHE_EN adds a one-entry k0->k_N cache so a decrypt with a recently used key skips expansion.
module aes_lite_core
  import aes_lite_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NUM_ROUNDS = 4,
  parameter int ROT        = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] key,
  output logic [DATA_W-1:0] dout,
  output logic              busy,
  output logic              done
);

  localparam int RW = cnt_width(NUM_ROUNDS);
  localparam logic [RW-1:0] R_ONE  = RW'(1);
  localparam logic [RW-1:0] R_LAST = RW'(NUM_ROUNDS);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] s_q, s_d, k_q, k_d, dout_q, dout_d;
  logic [RW-1:0]     r_q, r_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] rnd_s, rnd_k;

`ifdef AES_LITE_KEY_CACHE_EN
  logic              cache_valid_q, cache_valid_d;
  logic [DATA_W-1:0] cache_key_q, cache_key_d, cache_kn_q, cache_kn_d;
  logic [DATA_W-1:0] k0_q, k0_d, kn_q, kn_d;
`endif

  aes_lite_round #(
    .DATA_W(DATA_W),
    .ROT   (ROT)
  ) u_round (
    .dir_i(state_q == DEC),
    .s_i  (s_q),
    .k_i  (k_q),
    .rc_i (DATA_W'(r_q)),
    .s_o  (rnd_s),
    .k_o  (rnd_k)
  );

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    r_d     = r_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
`ifdef AES_LITE_KEY_CACHE_EN
    cache_valid_d = cache_valid_q;
    cache_key_d   = cache_key_q;
    cache_kn_d    = cache_kn_q;
    k0_d          = k0_q;
    kn_d          = kn_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          r_d = R_ONE;
          k_d = key;
`ifdef AES_LITE_KEY_CACHE_EN
          k0_d = key;
`endif
          if (mode == MODE_ENC) begin
            s_d     = din ^ key;
            state_d = ENC;
          end else begin
            s_d     = din;
            state_d = KEYEXP;
`ifdef AES_LITE_KEY_CACHE_EN
            if (cache_valid_q && (key == cache_key_q)) begin
              k_d     = cache_kn_q;
              kn_d    = cache_kn_q;
              r_d     = R_LAST;
              state_d = DEC;
            end
`endif
          end
        end
      end
      KEYEXP: begin
        k_d = rnd_k;
        if (r_q == R_LAST) begin
          state_d = DEC;
`ifdef AES_LITE_KEY_CACHE_EN
          kn_d = rnd_k;
`endif
        end else begin
          r_d = r_q + R_ONE;
        end
      end
      ENC: begin
        s_d = rnd_s;
        k_d = rnd_k;
        if (r_q == R_LAST) begin
          dout_d  = rnd_s;
          done_d  = 1'b1;
          state_d = IDLE;
`ifdef AES_LITE_KEY_CACHE_EN
          cache_valid_d = 1'b1;
          cache_key_d   = k0_q;
          cache_kn_d    = rnd_k;
`endif
        end else begin
          r_d = r_q + R_ONE;
        end
      end
      DEC: begin
        s_d = rnd_s;
        k_d = rnd_k;
        // At r=1 the inverse key step yields k0, so the final whitening folds into this cycle.
        if (r_q == R_ONE) begin
          dout_d  = rnd_s ^ rnd_k;
          done_d  = 1'b1;
          state_d = IDLE;
`ifdef AES_LITE_KEY_CACHE_EN
          cache_valid_d = 1'b1;
          cache_key_d   = k0_q;
          cache_kn_d    = kn_q;
`endif
        end else begin
          r_d = r_q - R_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      k_q     <= '0;
      r_q     <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
`ifdef AES_LITE_KEY_CACHE_EN
      cache_valid_q <= 1'b0;
      cache_key_q   <= '0;
      cache_kn_q    <= '0;
      k0_q          <= '0;
      kn_q          <= '0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
      r_q     <= r_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
`ifdef AES_LITE_KEY_CACHE_EN
      cache_valid_q <= cache_valid_d;
      cache_key_q   <= cache_key_d;
      cache_kn_q    <= cache_kn_d;
      k0_q          <= k0_d;
      kn_q          <= kn_d;
`endif
    end
  end

  assign dout = dout_q;
  assign done = done_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_aes_lite_core.sv
// Directed bench for aes_lite_core: a default (N=4) instance and a single-round (N=1) instance.
module tb_aes_lite_core;

  logic       clk = 1'b0;
  logic       rst_n, start, start1, mode;
  logic [7:0] din, key;
  logic [7:0] dout, dout1;
  logic       busy, done, busy1, done1;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

`ifdef AES_LITE_KEY_CACHE_EN
  localparam int DEC_RT_LAT = 4;
`else
  localparam int DEC_RT_LAT = 8;
`endif

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  aes_lite_core #(.DATA_W(8), .NUM_ROUNDS(4), .ROT(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .din(din), .key(key),
    .dout(dout), .busy(busy), .done(done)
  );

  aes_lite_core #(.DATA_W(8), .NUM_ROUNDS(1), .ROT(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode), .din(din), .key(key),
    .dout(dout1), .busy(busy1), .done(done1)
  );

  // Caller sits just after a rising edge; returns cycles from start edge to done edge.
  task automatic run_op(input logic m, input logic [7:0] d, input logic [7:0] k,
                        output int lat, output logic [7:0] res);
    mode = m; din = d; key = k; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = dout;
  endtask

  task automatic test_reset();
    start = 1'b0; start1 = 1'b0; mode = 1'b0; din = 8'h00; key = 8'h00;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected 00", dout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (dout1 !== 8'h00) begin errors++; $display("FAIL reset_dout1: got %h expected 00", dout1); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_round();
    logic [7:0] vin  [2] = '{8'h00, 8'h67};
    logic [7:0] vexp [2] = '{8'h67, 8'h00};
    int         vlat [2] = '{1, 2};
    int lat;
    for (int i = 0; i < 2; i++) begin
      mode = (i == 1); din = vin[i]; key = 8'h00; start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      lat = 0;
      while (done1 !== 1'b1 && lat < 50) begin
        @(posedge clk); #1;
        lat++;
      end
      checks++; if (lat != vlat[i]) begin errors++; $display("FAIL n1_latency[%0d]: got %0d expected %0d", i, lat, vlat[i]); end
      checks++; if (dout1 !== vexp[i]) begin errors++; $display("FAIL n1_dout[%0d]: got %h expected %h", i, dout1, vexp[i]); end
      checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL n1_busy_end[%0d]: got %b expected 0", i, busy1); end
    end
  endtask

  task automatic test_round_trip();
    logic [7:0] pt [5] = '{8'hAA, 8'h12, 8'hFF, 8'h00, 8'h5A};
    logic [7:0] ky [5] = '{8'h55, 8'h34, 8'hFF, 8'h00, 8'hA5};
    logic [7:0] ct [5] = '{8'hAC, 8'h36, 8'h5F, 8'h8F, 8'h61};
    int lat;
    logic [7:0] res;
    for (int i = 0; i < 5; i++) begin
      run_op(1'b0, pt[i], ky[i], lat, res);
      checks++; if (lat != 4) begin errors++; $display("FAIL rt_enc_latency[%0d]: got %0d expected 4", i, lat); end
      checks++; if (res !== ct[i]) begin errors++; $display("FAIL rt_enc_dout[%0d]: got %h expected %h", i, res, ct[i]); end
      run_op(1'b1, ct[i], ky[i], lat, res);
      checks++; if (lat != DEC_RT_LAT) begin errors++; $display("FAIL rt_dec_latency[%0d]: got %0d expected %0d", i, lat, DEC_RT_LAT); end
      checks++; if (res !== pt[i]) begin errors++; $display("FAIL rt_dec_dout[%0d]: got %h expected %h", i, res, pt[i]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_handshake();
    int d0, lat;
    d0 = done_cnt;
    mode = 1'b0; din = 8'hAA; key = 8'h55; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hs_busy_set: got %b expected 1", busy); end
    @(posedge clk); #1;
    mode = 1'b1; din = 8'h12; key = 8'h34; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; din = 8'h00; key = 8'h00;
    lat = 2;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat != 4) begin errors++; $display("FAIL hs_latency: got %0d expected 4", lat); end
    checks++; if (dout !== 8'hAC) begin errors++; $display("FAIL hs_dout: got %h expected ac", dout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hs_busy_clear: got %b expected 0", busy); end
    // Request issued in the done cycle must be taken.
    mode = 1'b0; din = 8'h12; key = 8'h34; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL hs_done_pulse: got %b expected 0", done); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hs_b2b_busy: got %b expected 1", busy); end
    checks++; if (dout !== 8'hAC) begin errors++; $display("FAIL hs_dout_hold: got %h expected ac", dout); end
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat != 4) begin errors++; $display("FAIL hs_b2b_latency: got %0d expected 4", lat); end
    checks++; if (dout !== 8'h36) begin errors++; $display("FAIL hs_b2b_dout: got %h expected 36", dout); end
    repeat (6) @(posedge clk);
    #1;
    checks++; if (done_cnt - d0 != 2) begin errors++; $display("FAIL hs_done_count: got %0d expected 2", done_cnt - d0); end
    checks++; if (dout !== 8'h36) begin errors++; $display("FAIL hs_dout_idle: got %h expected 36", dout); end
  endtask

  task automatic test_abort();
    int d0, lat;
    logic [7:0] res;
    d0 = done_cnt;
    mode = 1'b1; din = 8'hAC; key = 8'h55; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ab_busy_before: got %b expected 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ab_busy: got %b expected 0", busy); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL ab_dout: got %h expected 00", dout); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL ab_done: got %b expected 0", done); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL ab_no_done: got %0d pulses expected 0", done_cnt - d0); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL ab_dout_idle: got %h expected 00", dout); end
    run_op(1'b0, 8'hAA, 8'h55, lat, res);
    checks++; if (lat != 4) begin errors++; $display("FAIL ab_enc_latency: got %0d expected 4", lat); end
    checks++; if (res !== 8'hAC) begin errors++; $display("FAIL ab_enc_dout: got %h expected ac", res); end
  endtask

  initial begin
    test_reset();
    test_single_round();
    test_round_trip();
    test_handshake();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

endmodule
